// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: ADD/SUB/AND/OR/SLT with condition flags behind a
// valid/ready handshake, backed by a main output register plus one skid entry.
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic             Illegal
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             n;
        logic             c;
        logic             v;
        logic             ill;
    } entry_t;

    entry_t           nxt, main_q, skid_q;
    logic             main_vld, skid_vld, rdy_q;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   sum;
    logic             is_sub, acc, drain;

    // SUB shares the adder as A + ~B + 1, so Carry means "no borrow".
    always_comb begin
        is_sub = (ALUControl == OP_SUB);
        opb    = is_sub ? ~SrcB : SrcB;
        sum    = {1'b0, SrcA} + {1'b0, opb} + {{WIDTH{1'b0}}, is_sub};
        nxt    = '0;
        case (ALUControl)
            OP_ADD: begin
                nxt.res = sum[WIDTH-1:0];
                nxt.c   = sum[WIDTH];
                nxt.v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SUB: begin
                nxt.res = sum[WIDTH-1:0];
                nxt.c   = sum[WIDTH];
                nxt.v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_AND:  nxt.res = SrcA & SrcB;
            OP_OR:   nxt.res = SrcA | SrcB;
            OP_SLT:  nxt.res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: nxt.ill = 1'b1;
        endcase
        nxt.z = (nxt.res == '0);
        nxt.n = nxt.res[WIDTH-1];
    end

    assign acc   = in_valid & rdy_q;
    assign drain = main_vld & out_ready;

    // rdy_q mirrors "skid empty" but is kept as its own flop so in_ready is a clean register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (!skid_vld) begin
            if (acc) begin
                if (!main_vld || drain) begin
                    main_q   <= nxt;
                    main_vld <= 1'b1;
                end else begin
                    skid_q   <= nxt;
                    skid_vld <= 1'b1;
                    rdy_q    <= 1'b0;
                end
            end else if (drain) begin
                main_vld <= 1'b0;
            end
        end else if (drain) begin
            main_q   <= skid_q;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = main_vld;
    assign Result    = main_q.res;
    assign Zero      = main_q.z;
    assign Negative  = main_q.n;
    assign Carry     = main_q.c;
    assign Overflow  = main_q.v;
    assign Illegal   = main_q.ill;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage: opcode results/flags, back-pressure ordering, async reset.
module tb_alu_exec_stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA, SrcB, Result;
    logic             Zero, Negative, Carry, Overflow, Illegal;

    int n_chk = 0;
    int n_err = 0;

    alu_exec_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Zero(Zero), .Negative(Negative),
        .Carry(Carry), .Overflow(Overflow), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {Zero, Negative, Carry, Overflow, Illegal};
    endfunction

    task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid   = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
    endtask

    // One op accepted at the next edge, checked 1 ns after it (out_ready held high).
    task automatic op_chk(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] er, input logic [4:0] ef);
        drive(op, a, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, ".vld"}, 64'(out_valid), 64'd1);
        chk({tag, ".res"}, 64'(Result), 64'(er));
        chk({tag, ".flg"}, 64'(flags()), 64'(ef));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ALUControl = 3'b000; SrcA = '0; SrcB = '0;
        #1;
        chk("rst.vld", 64'(out_valid), 64'd0);
        chk("rst.rdy", 64'(in_ready), 64'd1);
        chk("rst.res", 64'(Result), 64'd0);
        chk("rst.flg", 64'(flags()), 64'd0);
        #11 rst = 1'b0;
        @(posedge clk); #1;

        // flags = {Zero, Negative, Carry, Overflow, Illegal}
        op_chk("add_ovf", 3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010);
        op_chk("add_cy",  3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10100);
        op_chk("sub_eq",  3'b001, 32'd5,        32'd5,        32'h00000000, 5'b10100);
        op_chk("sub_neg", 3'b001, 32'd3,        32'd5,        32'hFFFFFFFE, 5'b01000);
        op_chk("sub_ovf", 3'b001, 32'h80000000, 32'd1,        32'h7FFFFFFF, 5'b00110);
        op_chk("slt",     3'b101, 32'hFFFFFFFF, 32'd1,        32'h00000001, 5'b00000);
        op_chk("slt_f",   3'b101, 32'd1,        32'hFFFFFFFF, 32'h00000000, 5'b10000);
        op_chk("and",     3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b01000);
        op_chk("or",      3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 5'b01000);
        op_chk("ill110",  3'b110, 32'h12345678, 32'h12345678, 32'h00000000, 5'b10001);
        op_chk("after",   3'b000, 32'd1,        32'd1,        32'h00000002, 5'b00000);
        op_chk("ill100",  3'b100, 32'hFFFFFFFF, 32'd1,        32'h00000000, 5'b10001);
        op_chk("ill111",  3'b111, 32'd7,        32'd9,        32'h00000000, 5'b10001);

        @(posedge clk); #1;
        chk("drain.vld", 64'(out_valid), 64'd0);

        // Back-pressure: fill main then skid, third op must wait.
        out_ready = 1'b0;
        drive(3'b000, 32'd1, 32'd1);
        @(posedge clk); #1;
        chk("bp1.rdy", 64'(in_ready), 64'd1);
        chk("bp1.res", 64'(Result), 64'd2);
        drive(3'b000, 32'd2, 32'd2);
        @(posedge clk); #1;
        chk("bp2.rdy", 64'(in_ready), 64'd0);
        chk("bp2.res", 64'(Result), 64'd2);
        drive(3'b000, 32'd3, 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall.vld", 64'(out_valid), 64'd1);
            chk("stall.rdy", 64'(in_ready), 64'd0);
            chk("stall.res", 64'(Result), 64'd2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rel1.vld", 64'(out_valid), 64'd1);
        chk("rel1.res", 64'(Result), 64'd4);
        chk("rel1.rdy", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rel2.vld", 64'(out_valid), 64'd1);
        chk("rel2.res", 64'(Result), 64'd6);
        @(posedge clk); #1;
        chk("rel3.vld", 64'(out_valid), 64'd0);

        // Async reset while both entries are full.
        out_ready = 1'b0;
        drive(3'b000, 32'd10, 32'd10);
        @(posedge clk); #1;
        drive(3'b000, 32'd20, 32'd20);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("full.rdy", 64'(in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst.vld", 64'(out_valid), 64'd0);
        chk("arst.rdy", 64'(in_ready), 64'd1);
        chk("arst.res", 64'(Result), 64'd0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("post.vld", 64'(out_valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
